// File: rtl/mux_4_2_arbiter_if.sv
// Bundle of the request/data/grant signals shared between the request
// sources and the round-robin arbiter that owns the shared 2-bit mux.
interface mux_4_2_arbiter_if;
  logic [3:0] req;
  logic [1:0] I0;
  logic [1:0] I1;
  logic [1:0] I2;
  logic [1:0] I3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [1:0] Y;
  logic       valid;
  logic       last;

  // Request sources drive requests and data, observe grant and output.
  modport master (
    output req, I0, I1, I2, I3,
    input  gnt, sel, Y, valid, last
  );

  // The arbiter samples requests and data, drives grant and output.
  modport slave (
    input  req, I0, I1, I2, I3,
    output gnt, sel, Y, valid, last
  );
endinterface

// File: rtl/mux_4_2_arbiter.sv
// Round-robin arbiter sharing one 4:1 x 2-bit mux among four requesters.
// Each grant lasts at most HOLD cycles; handover between requesters has no
// idle bubble, and the previous owner always has the lowest priority.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any request
// BUSY  | requester sel owns the mux output, cnt cycles remain after this one

module mux_4_2 (
  input  logic [1:0] I0,
  input  logic [1:0] I1,
  input  logic [1:0] I2,
  input  logic [1:0] I3,
  input  logic [1:0] S,
  output logic [1:0] Y
);
  // Plain 4:1 selection of the 2-bit inputs.
  always_comb begin
    case (S)
      2'd0:    Y = I0;
      2'd1:    Y = I1;
      2'd2:    Y = I2;
      default: Y = I3;
    endcase
  end
endmodule

module mux_4_2_arbiter #(
  parameter int HOLD = 4
) (
  input logic clk,
  input logic rst,
  mux_4_2_arbiter_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] RELOAD = 8'(HOLD - 1);

  logic [0:0] state;
  logic [1:0] ptr;
  logic [7:0] cnt;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       last;

  logic [1:0] base;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       any_req;
  logic       grant_end;
  logic [1:0] y_mux;

  // At the end of a grant the owner becomes the last-served index in the
  // same edge, so the scan starts after sel rather than the stale ptr.
  assign base      = (state == BUSY) ? sel : ptr;
  assign any_req   = |bus.req;
  assign grant_end = (state == BUSY) && (!bus.req[sel] || cnt == 8'd0);

  // Rotating priority scan: base+1 first, base itself last.
  always_comb begin
    win   = base;
    idx   = base;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Grant sequencing, slot timer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd3;
      cnt   <= 8'd0;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (state == IDLE || grant_end) begin
      if (state == BUSY) ptr <= sel;
      if (any_req) begin
        state <= BUSY;
        sel   <= win;
        gnt   <= 4'b0001 << win;
        cnt   <= RELOAD;
        valid <= 1'b1;
        last  <= (RELOAD == 8'd0);
      end else begin
        state <= IDLE;
        gnt   <= 4'b0000;
        cnt   <= 8'd0;
        valid <= 1'b0;
        last  <= 1'b0;
      end
    end else begin
      cnt  <= cnt - 8'd1;
      last <= (cnt == 8'd1);
    end
  end

  mux_4_2 u_mux (
    .I0 (bus.I0),
    .I1 (bus.I1),
    .I2 (bus.I2),
    .I3 (bus.I3),
    .S  (sel),
    .Y  (y_mux)
  );

  assign bus.gnt   = gnt;
  assign bus.sel   = sel;
  assign bus.valid = valid;
  assign bus.last  = last;
  assign bus.Y     = y_mux;
endmodule

// File: tb/tb_mux_4_2_arbiter.sv
// Directed bench for mux_4_2_arbiter: one instance with HOLD=4 and one with
// HOLD=1, driven on the falling edge and observed on the next falling edge.
module tb_mux_4_2_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mux_4_2_arbiter_if bus_a ();
  mux_4_2_arbiter_if bus_b ();

  mux_4_2_arbiter #(.HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux_4_2_arbiter #(.HOLD(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then land on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus_a.req = 4'b0000; bus_a.I0 = 2'd0; bus_a.I1 = 2'd0; bus_a.I2 = 2'd0; bus_a.I3 = 2'd0;
    bus_b.req = 4'b0000; bus_b.I0 = 2'd0; bus_b.I1 = 2'd1; bus_b.I2 = 2'd2; bus_b.I3 = 2'd3;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt",   8'(bus_a.gnt), 8'h0);
    chk("rst_valid", 8'(bus_a.valid), 8'h0);
    chk("rst_sel",   8'(bus_a.sel), 8'h0);
    chk("rst_last",  8'(bus_a.last), 8'h0);
    rst = 1'b0;

    // Single requester 2, HOLD=4: grant reissued back-to-back.
    bus_a.req = 4'b0100;
    bus_a.I2  = 2'b10;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk("single_gnt",  8'(bus_a.gnt), 8'h04);
      chk("single_y",    8'(bus_a.Y), 8'h2);
      chk("single_last", 8'(bus_a.last), (c % 4 == 0) ? 8'h1 : 8'h0);
    end
    bus_a.req = 4'b0000;
    cyc();
    chk("single_idle_valid", 8'(bus_a.valid), 8'h0);
    chk("single_idle_gnt",   8'(bus_a.gnt), 8'h0);

    // Asynchronous reset in the middle of a grant.
    bus_a.req = 4'b0001;
    cyc();
    chk("pre_rst_valid", 8'(bus_a.valid), 8'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_gnt",   8'(bus_a.gnt), 8'h0);
    chk("async_valid", 8'(bus_a.valid), 8'h0);
    chk("async_sel",   8'(bus_a.sel), 8'h0);
    bus_a.req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      chk("idle_gnt",   8'(bus_a.gnt), 8'h0);
      chk("idle_valid", 8'(bus_a.valid), 8'h0);
      chk("idle_sel",   8'(bus_a.sel), 8'h0);
    end

    // Full contention: 0,1,2,3,0 each for HOLD cycles.
    do_reset();
    bus_a.I0 = 2'd0; bus_a.I1 = 2'd1; bus_a.I2 = 2'd2; bus_a.I3 = 2'd3;
    bus_a.req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      int owner;
      owner = ((c - 1) / 4) % 4;
      cyc();
      chk("rr_gnt",   8'(bus_a.gnt), 8'(1 << owner));
      chk("rr_y",     8'(bus_a.Y), 8'(owner));
      chk("rr_valid", 8'(bus_a.valid), 8'h1);
    end

    // Early release hands over with no bubble and a fresh slot.
    do_reset();
    bus_a.req = 4'b0011;
    cyc();
    chk("early_gnt_c1", 8'(bus_a.gnt), 8'h01);
    cyc();
    chk("early_gnt_c2", 8'(bus_a.gnt), 8'h01);
    bus_a.req = 4'b0010;
    for (int c = 3; c <= 6; c++) begin
      cyc();
      chk("early_gnt",   8'(bus_a.gnt), 8'h02);
      chk("early_valid", 8'(bus_a.valid), 8'h1);
      chk("early_last",  8'(bus_a.last), (c == 6) ? 8'h1 : 8'h0);
    end

    // Fairness between requesters 0 and 3.
    do_reset();
    bus_a.req = 4'b1001;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      chk("fair_gnt", 8'(bus_a.gnt), (((c - 1) / 4) % 2 == 0) ? 8'h01 : 8'h08);
    end

    // HOLD=1: alternate every cycle, last always high.
    do_reset();
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0110;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("h1_gnt",  8'(bus_b.gnt), (c % 2 == 1) ? 8'h02 : 8'h04);
      chk("h1_y",    8'(bus_b.Y), (c % 2 == 1) ? 8'h1 : 8'h2);
      chk("h1_last", 8'(bus_b.last), 8'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
